// File: rtl/ks_string_engine_if.sv
// Sample-voice bus between a controller and the Karplus-Strong string engine.
interface ks_string_engine_if #(
  parameter int WIDTH = 8,
  parameter int PW    = 6
);
  logic             pluck;
  logic [PW-1:0]    period;
  logic             tick;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  modport master (output pluck, period, tick, input out, out_valid, busy);
  modport slave  (input pluck, period, tick, output out, out_valid, busy);
endinterface

// File: rtl/ks_string_engine.sv
// Karplus-Strong string voice: LFSR noise fill on pluck, then per tick emits
// the oldest sample and writes back the floor average with its successor.
module ks_string_engine #(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 64,
  parameter int         PW        = 6,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  ks_string_engine_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    n_q, n_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we;
  logic [PW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  logic [PW-1:0]    pn;
  logic [PW-1:0]    nx_ptr;
  logic [WIDTH-1:0] y, nx, avg;
  logic [WIDTH:0]   sum;
  logic [7:0]       lfsr_nxt;

  // Period clamp, ring successor index, and the feedback average (9-bit sum, floor).
  always_comb begin
    pn       = (bus.period < PW'(2)) ? PW'(2) : bus.period;
    nx_ptr   = (rd_q == n_q - PW'(1)) ? '0 : rd_q + PW'(1);
    y        = mem_q[rd_q];
    nx       = mem_q[nx_ptr];
    sum      = {1'b0, y} + {1'b0, nx};
    avg      = WIDTH'(sum >> 1);
    lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Next-state logic: pluck loads noise, tick in RUN emits and feeds back.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    n_d     = n_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    we      = 1'b0;
    waddr   = wr_q;
    wdata   = WIDTH'(lfsr_q);
    case (state_q)
      S_IDLE: begin
        if (bus.pluck) begin
          n_d     = pn;
          wr_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        we     = 1'b1;
        lfsr_d = lfsr_nxt;
        wr_d   = wr_q + PW'(1);
        if (wr_q == n_q - PW'(1)) begin
          state_d = S_RUN;
          rd_d    = '0;
        end
      end
      S_RUN: begin
        // Pluck has priority over a coincident tick: no output, no write-back.
        if (bus.pluck) begin
          n_d     = pn;
          wr_d    = '0;
          rd_d    = '0;
          state_d = S_LOAD;
        end else if (bus.tick) begin
          we    = 1'b1;
          waddr = rd_q;
          wdata = avg;
          out_d = y;
          ov_d  = 1'b1;
          rd_d  = nx_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      n_q     <= PW'(2);
      lfsr_q  <= LFSR_SEED;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      n_q     <= n_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Delay-line store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = (state_q == S_LOAD);
endmodule

// File: tb/tb_ks_string_engine.sv
// Bench for ks_string_engine: fixed vectors, corner sequences, random run vs model.
module tb_ks_string_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ks_string_engine_if #(.WIDTH(8), .PW(6)) bus();
  ks_string_engine #(.WIDTH(8), .DEPTH(64), .PW(6), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: string contents as an array, load progress as a countdown.
  logic [7:0] m [64];
  int         mN, mrd, mbusy;
  bit         mrun, mvalid;
  logic [7:0] mlfsr, mout;
  int         fill0, fill1;

  typedef struct { int gap; logic [7:0] exp; } vec_t;
  vec_t tbl [8];

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mrun = 0; mbusy = 0; mlfsr = 8'hA5; mout = 8'h00; mvalid = 0; mrd = 0; mN = 2;
  endtask

  // One clock: drive inputs, advance the model, check outputs after the edge.
  task automatic cyc(input bit p, input int per, input bit t);
    int y, nx;
    bus.pluck = p; bus.period = per[5:0]; bus.tick = t;
    mvalid = 0;
    if (p && mbusy == 0) begin
      mN = (per < 2) ? 2 : per;
      for (int i = 0; i < mN; i++) begin
        m[i] = mlfsr;
        mlfsr = lfsr_step(mlfsr);
      end
      fill0 = m[0]; fill1 = m[1];
      mbusy = mN; mrun = 0; mrd = 0;
    end else if (mbusy > 0) begin
      mbusy--;
      if (mbusy == 0) begin mrun = 1; mrd = 0; end
    end else if (mrun && t) begin
      y = m[mrd];
      nx = m[(mrd + 1) % mN];
      m[mrd] = 8'((y + nx) / 2);
      mout = 8'(y);
      mvalid = 1;
      mrd = (mrd + 1) % mN;
    end
    @(posedge clk);
    @(negedge clk);
    bus.pluck = 0; bus.tick = 0;
    chk("busy", bus.busy, (mbusy > 0));
    chk("out_valid", bus.out_valid, mvalid);
    chk("out", bus.out, mout);
  endtask

  task automatic count_busy(output int bc);
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      cyc(0, 0, 0);
    end
  endtask

  initial begin
    int bc;
    tbl[0] = '{0, 8'hA5}; tbl[1] = '{0, 8'h4A}; tbl[2] = '{2, 8'h95}; tbl[3] = '{0, 8'h2A};
    tbl[4] = '{1, 8'h77}; tbl[5] = '{0, 8'h6F}; tbl[6] = '{3, 8'h5F}; tbl[7] = '{0, 8'h50};

    bus.pluck = 0; bus.period = 0; bus.tick = 0;
    #1 rst = 1;
    #2;
    chk("rst_out", bus.out, 8'h00);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Ticks in IDLE are ignored.
    repeat (2) cyc(0, 0, 1);

    // Load timing with N=4 and a tick during busy, then known fill/feedback values.
    cyc(1, 4, 0);
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      cyc(0, 0, (bc == 2));
    end
    chk("load4_cycles", bc, 4);
    foreach (tbl[i]) begin
      repeat (tbl[i].gap) cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk($sformatf("tbl%0d", i), bus.out, tbl[i].exp);
    end

    // Period clamp: 0 and 1 both load 2 samples.
    cyc(1, 0, 0);
    count_busy(bc);
    chk("clamp0_cycles", bc, 2);
    repeat (6) cyc(0, 0, 1);
    cyc(1, 1, 0);
    count_busy(bc);
    chk("clamp1_cycles", bc, 2);
    repeat (6) cyc(0, 0, 1);

    // Re-pluck together with a tick: pluck wins, LFSR continues.
    cyc(1, 5, 1);
    count_busy(bc);
    chk("repluck_cycles", bc, 5);
    cyc(0, 0, 1);
    checks++;
    if (bus.out === 8'hA5) begin
      errors++;
      $display("FAIL repluck_fresh actual=%0h required=not a5", bus.out);
    end

    // Maximum period: wrap 62 -> 0, tick 64 gives avg of first two fill samples.
    cyc(1, 63, 0);
    count_busy(bc);
    chk("load63_cycles", bc, 63);
    for (int k = 1; k <= 64; k++) cyc(0, 0, 1);
    chk("wrap_avg", bus.out, (fill0 + fill1) / 2);

    // Asynchronous reset mid-RUN.
    repeat (3) cyc(0, 0, 1);
    #2 rst = 1;
    #1;
    chk("midrun_rst_out", bus.out, 8'h00);
    chk("midrun_rst_valid", bus.out_valid, 1'b0);
    chk("midrun_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (4) cyc(0, 0, 1);

    // Random plucks, periods and ticks against the model.
    repeat (3000)
      cyc(($urandom_range(0, 39) == 0), int'($urandom_range(0, 63)), ($urandom_range(0, 2) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ks_string_engine.md
# ks_string_engine

Karplus-Strong string voice core: owns the circular sample store, fills it with an LFSR noise burst on a pluck, then on each sample tick reads the oldest sample out and writes back the two-point average. This is the feedback loop that closes around the delay line. The block is the read/feedback end of the 8-bit delay-line datapath and produces the audible sample stream for the downstream mixer/DAC stage.

## Interface
- WIDTH, 8: sample width in bits.
- DEPTH, 64: store size; the period range is 2..DEPTH-1.
- PW, 6: period port width, equal to log2(DEPTH).
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pluck  in  1  one-cycle request to excite the string.
- period  in  PW  string length N in samples; sampled only in the pluck cycle.
- tick  in  1  one-cycle sample-rate strobe.
- out  out  WIDTH  last sample read from the store (registered).
- out_valid  out  1  high for exactly one cycle when out updates.
- busy  out  1  high while the noise burst is being loaded.

## Operation
- Reset (async) values:
  - State: IDLE.
  - Outputs: out = 0, out_valid = 0, busy = 0.
  - Internal: rd_ptr = 0, wr_idx = 0, N = 2, lfsr = LFSR_SEED.
  - Store contents are not reset.
- N = max(period, 2), latched in the cycle pluck is accepted.
- LFSR (8-bit Fibonacci):
  - fb = l[7]^l[5]^l[4]^l[3].
  - next = {l[6:0], fb}.
  - Advances only on LOAD writes.
  - Not reseeded by pluck, so successive plucks differ.
- States:
  - IDLE:
    - pluck → LOAD; wr_idx = 0; busy = 1.
    - tick is ignored; out_valid stays 0.
  - LOAD:
    - Each clock: mem[wr_idx] = lfsr, advance lfsr, wr_idx++.
    - After the write to index N-1 → RUN; busy = 0; rd_ptr = 0.
    - pluck and tick are ignored.
  - RUN, on tick:
    - y = mem[rd_ptr]; nx = mem[(rd_ptr+1) mod N].
    - mem[rd_ptr] = (y + nx) >> 1, using a 9-bit sum truncated to 8 bits (floor).
    - out = y; out_valid = 1.
    - rd_ptr = (rd_ptr+1) mod N; wraps N-1 → 0.
  - RUN, on pluck: re-pluck → LOAD with the newly latched N.
    - rd_ptr resets.
    - The store is overwritten from index 0.
- pluck and tick in the same RUN cycle: pluck wins; no output, no write-back.
- Both reads in a tick use pre-update contents. At the wrap (rd_ptr = N-1), nx = mem[0] already holds its averaged value from the previous lap.
- Samples are unsigned. With no new pluck the waveform decays toward a constant (floor averaging).

## Timing
- pluck high in cycle c:
  - busy = 1 in cycles c+1 .. c+N.
  - State is RUN from cycle c+N+1.
  - First tick is honoured at c+N+1.
- Tick latency: tick high in cycle t → out/out_valid valid in cycle t+1.
  - out holds its value until the next honoured tick.
- out_valid is never high in consecutive cycles unless tick is.
- Back-to-back ticks in RUN are supported at one sample per clock.
- Reset asserted mid-LOAD or mid-RUN: all outputs return to reset values immediately (async). Operation resumes only after a fresh pluck.

## Test plan
- Reset check: assert rst mid-RUN → out = 0, out_valid = 0, busy = 0 within the same cycle; ticks after release give no out_valid.
- Load timing: pluck with period = 4 at cycle c → busy high for exactly cycles c+1..c+4; a tick during busy gives no out_valid.
- Noise fill and feedback: seed A5, N = 4, ticks 1..5 → out = A5, 4A, 95, 2A, then 77. Store after lap 1 = 77, 6F, 5F, 50.
- Period clamp: period = 0 and period = 1 → busy lasts 2 cycles. Outputs alternate between indices 0/1 with averaging.
- Re-pluck: pluck while RUN, together with a tick, in the same cycle → no out_valid that cycle. busy is high for the new N cycles. The LFSR continues from its prior state (first new sample ≠ A5).
- Max period: period = 63 → 63 load cycles. rd_ptr wraps 62 → 0, and tick 64 outputs avg(first two fill samples).
